// File: rtl/gi_pkg.sv
// Shared types for the garbled-inference datapath: word width, word type and
// the dot-product stage FSM encoding.
package gi_pkg;

    localparam int unsigned WORD_W = 64;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        OUT
    } dot_state_t;

endpackage

// File: rtl/mul64_lo.sv
// Registered 64x64 multiplier keeping only the low 64 bits of the product.
// Signed and unsigned low halves match, so no sign handling is needed here.
module mul64_lo
    import gi_pkg::*;
(
    input  logic  clk,
    input  logic  en_i,
    input  word_t a_i,
    input  word_t b_i,
    output word_t p_o
);

    word_t p_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            p_q <= a_i * b_i;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/masked_dot64.sv
// Sequential masked dot product: sum of x*w mod 2^64 plus a per-vector
// correction word, with length checking and a valid/ready result port.
module masked_dot64
    import gi_pkg::*;
#(
    parameter int LEN = 16,
    parameter int CW  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_x,
    input  logic [63:0] in_w,
    input  logic        in_last,
    input  logic [63:0] in_corr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_err
);

    dot_state_t    state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    word_t         out_data_q;
    logic          out_err_q;
    word_t         acc_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          p_valid_q;
    logic          p_last_q;
    logic          p_err_q;
    word_t         p_corr_q;
    word_t         prod;

    logic  accept;
    logic  cnt_at_end;
    logic  beat_last;
    logic  beat_err;
    word_t sum_d;

    mul64_lo u_mul (
        .clk  (clk),
        .en_i (accept),
        .a_i  (in_x),
        .b_i  (in_w),
        .p_o  (prod)
    );

    always_comb begin
        accept     = in_valid && in_ready_q;
        cnt_at_end = (cnt_q == CW'(LEN - 1));
        // A beat at the final count ends the vector even without in_last.
        beat_last  = in_last || cnt_at_end;
        beat_err   = in_last != cnt_at_end;
        cnt_d      = beat_last ? '0 : cnt_q + 1'b1;
        sum_d      = acc_q + prod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_err_q     <= 1'b0;
            p_corr_q    <= '0;
        end else begin
            p_valid_q <= accept;
            if (accept) begin
                p_last_q <= beat_last;
                p_err_q  <= beat_err;
                cnt_q    <= cnt_d;
                if (beat_last) begin
                    p_corr_q <= in_corr;
                end
            end

            if (p_valid_q) begin
                if (p_last_q) begin
                    out_data_q <= sum_d + p_corr_q;
                    out_err_q  <= p_err_q;
                    acc_q      <= '0;
                end else begin
                    acc_q <= sum_d;
                end
            end

            case (state_q)
                ACC: begin
                    if (accept && beat_last) begin
                        state_q    <= DRAIN;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    state_q     <= OUT;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= ACC;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ACC;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_masked_dot64.sv
// Directed bench for masked_dot64: one LEN=4 and one LEN=2 instance sharing
// stimulus, selected by sel.
module tb_masked_dot64;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic [63:0] in_x;
    logic [63:0] in_w;
    logic        in_last;
    logic [63:0] in_corr;
    logic        out_ready;

    logic        ir4, ov4, oe4, ir2, ov2, oe2;
    logic [63:0] od4, od2;
    logic        iv4, iv2;

    logic        iready, ovalid, oerr;
    logic [63:0] odata;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign iv4    = in_valid && !sel;
    assign iv2    = in_valid && sel;
    assign iready = sel ? ir2 : ir4;
    assign ovalid = sel ? ov2 : ov4;
    assign odata  = sel ? od2 : od4;
    assign oerr   = sel ? oe2 : oe4;

    masked_dot64 #(.LEN(4), .CW(16)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .in_x(in_x), .in_w(in_w), .in_last(in_last), .in_corr(in_corr),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_err(oe4)
    );

    masked_dot64 #(.LEN(2), .CW(16)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .in_x(in_x), .in_w(in_w), .in_last(in_last), .in_corr(in_corr),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_err(oe2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one element and hold it until the selected DUT accepts it.
    task automatic beat(input logic [63:0] x, input logic [63:0] w,
                        input logic last, input logic [63:0] corr);
        int waited = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        in_last  = last;
        in_corr  = corr;
        while (!iready && waited < 50) begin
            tick();
            waited++;
        end
        if (!iready) begin
            nvec++;
            nerr++;
            $display("FAIL beat_timeout: in_ready observed 0 required 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_last   = 1'b0;
        in_corr   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 64'(iready), 64'd0);
        chk("rst_out_valid", 64'(ovalid), 64'd0);
        chk("rst_out_data", odata, 64'd0);
        chk("rst_out_err", 64'(oerr), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_release_in_ready", 64'(iready), 64'd1);

        // Basic LEN=4: 5+12+21+32+10 = 80
        beat(64'd1, 64'd5, 1'b0, 64'd0);
        beat(64'd2, 64'd6, 1'b0, 64'd0);
        beat(64'd3, 64'd7, 1'b0, 64'd0);
        beat(64'd4, 64'd8, 1'b1, 64'd10);
        chk("basic_valid_t1", 64'(ovalid), 64'd0);
        chk("basic_ready_t1", 64'(iready), 64'd0);
        tick();
        chk("basic_valid_t2", 64'(ovalid), 64'd1);
        chk("basic_data", odata, 64'd80);
        chk("basic_err", 64'(oerr), 64'd0);
        tick();
        chk("basic_valid_after", 64'(ovalid), 64'd0);
        chk("basic_ready_after", 64'(iready), 64'd1);

        // Wrap and sign, LEN=2: 2^63*2 = 0, 3*(-1) = -3
        sel = 1'b1;
        beat(64'h8000_0000_0000_0000, 64'd2, 1'b0, 64'd0);
        beat(64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0);
        tick();
        chk("wrap_valid", 64'(ovalid), 64'd1);
        chk("wrap_data", odata, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("wrap_err", 64'(oerr), 64'd0);
        tick();
        chk("wrap_ready_after", 64'(iready), 64'd1);

        // Masked end-to-end, LEN=2: x+r={10,4}, w={2,1}, corr=-(23)-100
        beat(64'd10, 64'd2, 1'b0, 64'd0);
        beat(64'd4, 64'd1, 1'b1, 64'd0 - 64'd123);
        tick();
        chk("masked_valid", 64'(ovalid), 64'd1);
        chk("masked_unmask", odata + 64'd100, 64'd1);
        tick();

        // Backpressure, LEN=4: 4*2 + 1 = 9, held for 5 stalled cycles
        sel       = 1'b0;
        out_ready = 1'b0;
        beat(64'd1, 64'd2, 1'b0, 64'd0);
        beat(64'd1, 64'd2, 1'b0, 64'd0);
        beat(64'd1, 64'd2, 1'b0, 64'd0);
        beat(64'd1, 64'd2, 1'b1, 64'd1);
        tick();
        in_valid = 1'b1;
        in_x     = 64'd1;
        in_w     = 64'd1;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(ovalid), 64'd1);
            chk("bp_data", odata, 64'd9);
            chk("bp_err", 64'(oerr), 64'd0);
            chk("bp_in_ready", 64'(iready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_valid_after", 64'(ovalid), 64'd0);
        chk("bp_ready_after", 64'(iready), 64'd1);

        // Early in_last on 3rd beat: 1+2+3 = 6, error flagged
        beat(64'd1, 64'd1, 1'b0, 64'd0);
        beat(64'd2, 64'd1, 1'b0, 64'd0);
        beat(64'd3, 64'd1, 1'b1, 64'd0);
        tick();
        chk("early_valid", 64'(ovalid), 64'd1);
        chk("early_data", odata, 64'd6);
        chk("early_err", 64'(oerr), 64'd1);
        tick();

        // Missing in_last: forced end after 4th beat, corr taken from it
        beat(64'd1, 64'd3, 1'b0, 64'd99);
        beat(64'd1, 64'd3, 1'b0, 64'd99);
        beat(64'd1, 64'd3, 1'b0, 64'd99);
        beat(64'd1, 64'd3, 1'b0, 64'd5);
        chk("forced_in_ready", 64'(iready), 64'd0);
        tick();
        chk("forced_valid", 64'(ovalid), 64'd1);
        chk("forced_data", odata, 64'd17);
        chk("forced_err", 64'(oerr), 64'd1);
        tick();

        // Reset after 2 of 4 elements discards the vector
        beat(64'd7, 64'd7, 1'b0, 64'd0);
        beat(64'd7, 64'd7, 1'b0, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 64'(iready), 64'd0);
        chk("midrst_valid", 64'(ovalid), 64'd0);
        chk("midrst_data", odata, 64'd0);
        tick();
        chk("midrst_in_ready_rise", 64'(iready), 64'd1);
        tick();
        tick();
        chk("midrst_no_valid", 64'(ovalid), 64'd0);
        beat(64'd1, 64'd1, 1'b0, 64'd0);
        beat(64'd1, 64'd1, 1'b0, 64'd0);
        beat(64'd1, 64'd1, 1'b0, 64'd0);
        beat(64'd1, 64'd1, 1'b1, 64'd0);
        tick();
        chk("clean_valid", 64'(ovalid), 64'd1);
        chk("clean_data", odata, 64'd4);
        chk("clean_err", 64'(oerr), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
